ex_mem_stage_skid: RTL and testbench

//  Parametrised EX->MEM pipeline stage with valid/ready handshake, 2-entry skid buffer,

---
 rtl/ex_mem_stage_skid.sv | 143 ++++++++++++++
 tb/tb_ex_mem_stage_skid.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_skid.sv
// EX->MEM pipeline register with valid/ready handshake, a 2-entry skid buffer,
// synchronous flush, mul/div result selection and a saturating md-stall counter.
module ex_mem_stage_skid #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic [REG_W-1:0]  ex_write_reg,
    input  logic [DATA_W-1:0] ex_qb,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_md_result,
    input  logic              ex_md_start,
    input  logic              md_busy,
    input  logic [DATA_W-1:0] ex_pc,
    output logic              me_valid,
    input  logic              me_ready,
    output logic [CTRL_W-1:0] me_ctrl,
    output logic [REG_W-1:0]  me_write_reg,
    output logic [DATA_W-1:0] me_result,
    output logic [DATA_W-1:0] me_qb,
    output logic [DATA_W-1:0] me_pc,
    output logic [CNT_W-1:0]  md_stall_cnt
);

    localparam int ENTRY_W  = CTRL_W + REG_W + 3 * DATA_W;
    localparam int QB_LO    = DATA_W;
    localparam int RES_LO   = 2 * DATA_W;
    localparam int WR_LO    = 3 * DATA_W;
    localparam int CTRL_LO  = 3 * DATA_W + REG_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ENTRY_W-1:0]  m_entry;
    logic [ENTRY_W-1:0]  s_entry;
    logic [ENTRY_W-1:0]  in_entry;
    logic [DATA_W-1:0]   sel_result;
    logic                md_hold;
    logic                push;
    logic                pop;
    logic                load_m_in;
    logic                load_m_skid;
    logic                load_s;

    assign md_hold    = ex_md_start & md_busy;
    assign ex_ready   = (state != FULL) & ~md_hold;
    assign me_valid   = (state != EMPTY);
    assign push       = ex_valid & ex_ready & ~flush;
    assign pop        = me_valid & me_ready;
    assign sel_result = (ex_md_start & ~md_busy) ? ex_md_result : ex_alu_result;
    assign in_entry   = {ex_ctrl, ex_write_reg, sel_result, ex_qb, ex_pc};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // M always feeds the outputs; S only absorbs the one entry that arrives while M is stalled.
    always_comb begin
        state_next  = state;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                    load_m_in  = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_m_in = 1'b1;
                end else if (push) begin
                    state_next = FULL;
                    load_s     = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_next  = ONE;
                    load_m_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next  = EMPTY;
            load_m_in   = 1'b0;
            load_m_skid = 1'b0;
            load_s      = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_entry <= '0;
            s_entry <= '0;
        end else begin
            if (load_m_in) begin
                m_entry <= in_entry;
            end else if (load_m_skid) begin
                m_entry <= s_entry;
            end
            if (load_s) begin
                s_entry <= in_entry;
            end
        end
    end

    // Only the stall cycles of a real instruction are counted; the counter sticks at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_stall_cnt <= '0;
        end else if (ex_valid && md_hold && !flush && (md_stall_cnt != {CNT_W{1'b1}})) begin
            md_stall_cnt <= md_stall_cnt + 1'b1;
        end
    end

    assign me_ctrl      = me_valid ? m_entry[ENTRY_W-1:CTRL_LO] : '0;
    assign me_write_reg = me_valid ? m_entry[CTRL_LO-1:WR_LO] : '0;
    assign me_result    = m_entry[WR_LO-1:RES_LO];
    assign me_qb        = m_entry[RES_LO-1:QB_LO];
    assign me_pc        = m_entry[QB_LO-1:0];

endmodule

// File: tb/tb_ex_mem_stage_skid.sv
// Self-checking bench for ex_mem_stage_skid: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_ex_mem_stage_skid;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    logic              ex_valid;
    logic              ex_ready;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [REG_W-1:0]  ex_write_reg;
    logic [DATA_W-1:0] ex_qb;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_md_result;
    logic              ex_md_start;
    logic              md_busy;
    logic [DATA_W-1:0] ex_pc;
    logic              me_valid;
    logic              me_ready;
    logic [CTRL_W-1:0] me_ctrl;
    logic [REG_W-1:0]  me_write_reg;
    logic [DATA_W-1:0] me_result;
    logic [DATA_W-1:0] me_qb;
    logic [DATA_W-1:0] me_pc;
    logic [CNT_W-1:0]  md_stall_cnt;

    ex_mem_stage_skid #(
        .DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl),
        .ex_write_reg(ex_write_reg), .ex_qb(ex_qb), .ex_alu_result(ex_alu_result),
        .ex_md_result(ex_md_result), .ex_md_start(ex_md_start), .md_busy(md_busy),
        .ex_pc(ex_pc), .me_valid(me_valid), .me_ready(me_ready), .me_ctrl(me_ctrl),
        .me_write_reg(me_write_reg), .me_result(me_result), .me_qb(me_qb),
        .me_pc(me_pc), .md_stall_cnt(md_stall_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_W-1:0]  wr;
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] qb;
        logic [DATA_W-1:0] pc;
    } entry_t;

    // Reference: a FIFO of at most two instructions plus a saturating stall count.
    entry_t model_q[$];
    int     model_cnt;
    int     checks = 0;
    int     errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] ctrl, input logic [REG_W-1:0] wr,
                                 input logic [DATA_W-1:0] qb, input logic [DATA_W-1:0] alu,
                                 input logic [DATA_W-1:0] md, input logic start, input logic busy,
                                 input logic [DATA_W-1:0] pc, input logic rdy, input logic fl);
        ex_valid      = v;
        ex_ctrl       = ctrl;
        ex_write_reg  = wr;
        ex_qb         = qb;
        ex_alu_result = alu;
        ex_md_result  = md;
        ex_md_start   = start;
        md_busy       = busy;
        ex_pc         = pc;
        me_ready      = rdy;
        flush         = fl;
        #2;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0, rdy, 1'b0);
    endtask

    task automatic checkModel();
        bit has = (model_q.size() != 0);
        bit exp_ready = (model_q.size() < 2) && !(ex_md_start && md_busy);
        checkOutput("ex_ready", 64'(ex_ready), 64'(exp_ready));
        checkOutput("me_valid", 64'(me_valid), 64'(has));
        checkOutput("md_stall_cnt", 64'(md_stall_cnt), 64'(model_cnt));
        if (has) begin
            checkOutput("me_ctrl", 64'(me_ctrl), 64'(model_q[0].ctrl));
            checkOutput("me_write_reg", 64'(me_write_reg), 64'(model_q[0].wr));
            checkOutput("me_result", 64'(me_result), 64'(model_q[0].res));
            checkOutput("me_qb", 64'(me_qb), 64'(model_q[0].qb));
            checkOutput("me_pc", 64'(me_pc), 64'(model_q[0].pc));
        end else begin
            checkOutput("me_ctrl_gated", 64'(me_ctrl), 64'd0);
            checkOutput("me_write_reg_gated", 64'(me_write_reg), 64'd0);
        end
    endtask

    // Called with inputs already applied; checks, clocks once and advances the model.
    task automatic stepCycle();
        entry_t e;
        bit hold, push, pop;
        checkModel();
        hold    = ex_md_start && md_busy;
        push    = ex_valid && (model_q.size() < 2) && !hold && !flush;
        pop     = (model_q.size() != 0) && me_ready;
        e.ctrl  = ex_ctrl;
        e.wr    = ex_write_reg;
        e.res   = (ex_md_start && !md_busy) ? ex_md_result : ex_alu_result;
        e.qb    = ex_qb;
        e.pc    = ex_pc;
        if (ex_valid && hold && !flush && model_cnt < CNT_MAX) model_cnt++;
        @(posedge clock);
        #1;
        if (flush) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back(e);
        end
    endtask

    initial begin
        model_cnt = 0;
        reset = 1'b1;
        idle(1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        checkOutput("rst_me_valid", 64'(me_valid), 64'd0);
        checkOutput("rst_ex_ready", 64'(ex_ready), 64'd1);
        checkOutput("rst_me_result", 64'(me_result), 64'd0);
        checkOutput("rst_me_pc", 64'(me_pc), 64'd0);
        checkOutput("rst_cnt", 64'(md_stall_cnt), 64'd0);
        reset = 1'b0;

        $display("[TB] single ALU op");
        applyStimulus(1'b1, 16'h00A5, 5'd3, 32'h5, 32'h11, 32'h0, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0);
        stepCycle();
        idle(1'b1);
        checkOutput("t1_result", 64'(me_result), 64'h11);
        checkOutput("t1_pc", 64'(me_pc), 64'h40);
        stepCycle();
        checkOutput("t1_drained", 64'(me_valid), 64'd0);
        checkOutput("t1_ctrl_zero", 64'(me_ctrl), 64'd0);

        $display("[TB] skid fill and drain");
        applyStimulus(1'b1, 16'h0001, 5'd1, 32'hA0, 32'hAAAA, 32'h0, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 16'h0002, 5'd2, 32'hB0, 32'hBBBB, 32'h0, 1'b0, 1'b0, 32'h104, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 16'h0003, 5'd3, 32'hC0, 32'hCCCC, 32'h0, 1'b0, 1'b0, 32'h108, 1'b0, 1'b0);
        checkOutput("t2_full_ready", 64'(ex_ready), 64'd0);
        stepCycle();
        idle(1'b1);
        checkOutput("t2_first", 64'(me_result), 64'hAAAA);
        stepCycle();
        idle(1'b1);
        checkOutput("t2_second", 64'(me_result), 64'hBBBB);
        stepCycle();
        idle(1'b1);
        stepCycle();

        $display("[TB] mul/div stall");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h0010, 5'd7, 32'h0, 32'h1234, 32'h0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
            stepCycle();
        end
        checkOutput("t3_cnt", 64'(md_stall_cnt), 64'd3);
        applyStimulus(1'b1, 16'h0010, 5'd7, 32'h0, 32'h1234, 32'hBEEF, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0);
        stepCycle();
        idle(1'b1);
        checkOutput("t3_md_result", 64'(me_result), 64'hBEEF);
        stepCycle();

        $display("[TB] flush while full");
        applyStimulus(1'b1, 16'h0021, 5'd4, 32'h1, 32'h71, 32'h0, 1'b0, 1'b0, 32'h300, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 16'h0022, 5'd5, 32'h2, 32'h72, 32'h0, 1'b0, 1'b0, 32'h304, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 16'h0023, 5'd6, 32'h3, 32'h73, 32'h0, 1'b0, 1'b0, 32'h308, 1'b0, 1'b1);
        stepCycle();
        idle(1'b1);
        checkOutput("t4_valid", 64'(me_valid), 64'd0);
        checkOutput("t4_ctrl", 64'(me_ctrl), 64'd0);
        checkOutput("t4_ready", 64'(ex_ready), 64'd1);
        stepCycle();

        $display("[TB] stall counter saturation");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 16'h0030, 5'd9, 32'h0, 32'h55, 32'h66, 1'b1, 1'b1, 32'h400, 1'b1, 1'b0);
            stepCycle();
        end
        checkOutput("t5_sat", 64'(md_stall_cnt), 64'(CNT_MAX));

        $display("[TB] async reset while full");
        applyStimulus(1'b1, 16'h0041, 5'd1, 32'h9, 32'h91, 32'h0, 1'b0, 1'b0, 32'h500, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 16'h0042, 5'd2, 32'h9, 32'h92, 32'h0, 1'b0, 1'b0, 32'h504, 1'b0, 1'b0);
        stepCycle();
        idle(1'b0);
        checkOutput("t6_full", 64'(ex_ready), 64'd0);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("t6_valid", 64'(me_valid), 64'd0);
        checkOutput("t6_ctrl", 64'(me_ctrl), 64'd0);
        checkOutput("t6_result", 64'(me_result), 64'd0);
        checkOutput("t6_pc", 64'(me_pc), 64'd0);
        checkOutput("t6_cnt", 64'(md_stall_cnt), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_q.delete();
        model_cnt = 0;
        idle(1'b1);
        checkOutput("t6_ready_after", 64'(ex_ready), 64'd1);
        stepCycle();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic start;
            start = ($urandom_range(0, 4) == 0);
            applyStimulus(($urandom_range(0, 3) != 0), 16'($urandom), 5'($urandom), $urandom, $urandom,
                          $urandom, start, start && ($urandom_range(0, 2) == 0), $urandom,
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
